// File: rtl/unidade_controle.sv
// Multi-cycle control FSM for the 16-bit processor: fetches and decodes instruction
// words, then sequences operand read, ALU execution, memory access and write-back.
module unidade_controle (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] InstrIn,
    input  logic        InstrValid,
    output logic        InstrReady,
    input  logic        ResultNZ,
    input  logic        MemAck,
    output logic [2:0]  RdAddrA,
    output logic [2:0]  RdAddrB,
    output logic [3:0]  ULAOp,
    output logic [1:0]  WbSel,
    output logic [15:0] ImmOut,
    output logic        RegWrite,
    output logic [2:0]  WrAddr,
    output logic        MemReq,
    output logic        MemWe,
    output logic        Done,
    output logic        IllegalOp
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StImm    = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5
    } state_e;

    localparam logic [3:0] OpLd   = 4'b0000;
    localparam logic [3:0] OpSt   = 4'b0001;
    localparam logic [3:0] OpMvnz = 4'b0010;
    localparam logic [3:0] OpMv   = 4'b0011;
    localparam logic [3:0] OpMvi  = 4'b0100;
    localparam logic [3:0] OpAdd  = 4'b0101;
    localparam logic [3:0] OpSrl  = 4'b1010;

    state_e      r_state;
    state_e      w_state_next;
    logic [15:0] r_ir;
    logic [15:0] r_imm;
    logic        r_nz;

    logic [3:0]  w_op;
    logic        w_is_alu;
    logic        w_is_illegal;
    logic        w_unused_ir;

    assign w_op         = r_ir[15:12];
    assign w_is_alu     = (w_op >= OpAdd) && (w_op <= OpSrl);
    assign w_is_illegal = (w_op > OpSrl);
    assign w_unused_ir  = ^r_ir[5:0];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_ir  <= '0;
            r_imm <= '0;
            r_nz  <= 1'b0;
        end else begin
            if (r_state == StFetch && InstrValid) r_ir <= InstrIn;
            if (r_state == StImm && InstrValid)   r_imm <= InstrIn;
            if (r_state == StExec)                r_nz <= ResultNZ;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFetch:  if (InstrValid) w_state_next = StDecode;
            StDecode: begin
                if (w_is_illegal)                          w_state_next = StFetch;
                else if (w_op == OpMvi)                    w_state_next = StImm;
                else if (w_op == OpLd || w_op == OpSt)     w_state_next = StMem;
                else if (w_is_alu)                         w_state_next = StExec;
                else                                       w_state_next = StWb;
            end
            StImm:    if (InstrValid) w_state_next = StWb;
            StExec:   w_state_next = StWb;
            StMem:    if (MemAck) w_state_next = StWb;
            StWb:     w_state_next = StFetch;
            default:  w_state_next = StFetch;
        endcase
    end

    always_comb begin
        InstrReady = 1'b0;
        ULAOp      = 4'b0000;
        WbSel      = 2'b00;
        RegWrite   = 1'b0;
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        Done       = 1'b0;
        IllegalOp  = 1'b0;
        unique case (r_state)
            // Gated by Resetn so the handshake is closed while reset is held.
            StFetch:  InstrReady = Resetn;
            StDecode: IllegalOp = w_is_illegal;
            StImm:    InstrReady = Resetn;
            StExec:   ULAOp = w_op;
            StMem: begin
                MemReq = 1'b1;
                MemWe  = (w_op == OpSt);
            end
            StWb: begin
                Done     = 1'b1;
                RegWrite = !((w_op == OpSt) || (w_op == OpMvnz && !r_nz));
                if (w_is_alu) ULAOp = w_op;
                if (w_op == OpMv || w_op == OpMvnz) WbSel = 2'b01;
                else if (w_op == OpMvi)             WbSel = 2'b10;
                else if (w_op == OpLd)              WbSel = 2'b11;
                else                                WbSel = 2'b00;
            end
            default: ;
        endcase
    end

    assign RdAddrA = r_ir[11:9];
    assign RdAddrB = r_ir[8:6];
    assign WrAddr  = r_ir[11:9];
    assign ImmOut  = r_imm;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed vector table, reset-abort sequence,
// and randomized instruction stream checked against a latency/effect reference model.
module tb_unidade_controle;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        result_nz;
    logic        mem_ack;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [3:0]  ula_op;
    logic [1:0]  wb_sel;
    logic [15:0] imm_out;
    logic        reg_write;
    logic [2:0]  wr_addr;
    logic        mem_req;
    logic        mem_we;
    logic        done;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;

    unidade_controle dut (
        .Clock     (clk),
        .Resetn    (rst_n),
        .InstrIn   (instr_in),
        .InstrValid(instr_valid),
        .InstrReady(instr_ready),
        .ResultNZ  (result_nz),
        .MemAck    (mem_ack),
        .RdAddrA   (rd_addr_a),
        .RdAddrB   (rd_addr_b),
        .ULAOp     (ula_op),
        .WbSel     (wb_sel),
        .ImmOut    (imm_out),
        .RegWrite  (reg_write),
        .WrAddr    (wr_addr),
        .MemReq    (mem_req),
        .MemWe     (mem_we),
        .Done      (done),
        .IllegalOp (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [15:0] imm;
        int          d;
        int          w;
        logic        nzin;
        int          lat;
        logic        rw;
        logic [1:0]  wbsel;
        logic [3:0]  ula;
        logic        ill;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller is positioned #1 after a rising edge with the DUT in FETCH.
    task automatic do_instr(input logic [15:0] word, input logic [15:0] imm, input int d,
                            input int w, input logic nzin, input int lat, input logic exp_rw,
                            input logic [1:0] exp_wbsel, input logic [3:0] exp_ula,
                            input logic exp_ill);
        logic [3:0] op;
        logic       alu;
        op  = word[15:12];
        alu = (op >= 4'd5) && (op <= 4'd10);
        instr_valid = 1'b1;
        instr_in    = word;
        result_nz   = 1'($urandom);
        mem_ack     = 1'($urandom);
        @(negedge clk);
        chk("ready_fetch", instr_ready, 1);
        @(posedge clk);
        #1;
        for (int k = 1; k <= lat; k++) begin
            instr_valid = 1'($urandom);
            instr_in    = 16'($urandom);
            mem_ack     = 1'($urandom);
            result_nz   = 1'($urandom);
            if (op == 4'd4 && k >= 2 && k <= 2 + d) begin
                instr_valid = (k == 2 + d);
                if (k == 2 + d) instr_in = imm;
            end
            if (op <= 4'd1 && k >= 2 && k <= 2 + w) mem_ack = (k == 2 + w);
            if (alu && k == 2) result_nz = nzin;
            @(negedge clk);
            chk("done", done, (k == lat) && !exp_ill);
            chk("illegal", illegal_op, exp_ill && k == 1);
            chk("memreq", mem_req, op <= 4'd1 && k >= 2 && k < lat);
            if (op <= 4'd1 && k >= 2 && k < lat) chk("memwe", mem_we, op == 4'd1);
            chk("ready", instr_ready, op == 4'd4 && k >= 2 && k < lat);
            chk("rdaddr_a", rd_addr_a, word[11:9]);
            chk("rdaddr_b", rd_addr_b, word[8:6]);
            if (k == lat && !exp_ill) begin
                chk("wb_regwrite", reg_write, exp_rw);
                if (op != 4'd1) chk("wb_wbsel", wb_sel, exp_wbsel);
                chk("wb_wraddr", wr_addr, word[11:9]);
                chk("wb_ulaop", ula_op, exp_ula);
                if (op == 4'd4) chk("immout", imm_out, imm);
            end else begin
                chk("regwrite_idle", reg_write, 0);
                chk("wbsel_idle", wb_sel, 0);
                chk("ulaop", ula_op, (alu && k == 2) ? op : 4'd0);
            end
            if (k < lat) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic        model_nz;
    logic [3:0]  r_op;
    logic [15:0] r_word;
    logic [15:0] r_imm;
    int          r_d;
    int          r_w;
    logic        r_nzin;
    int          e_lat;
    logic        e_rw;
    logic [1:0]  e_wbsel;
    logic [3:0]  e_ula;
    logic        e_ill;

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_in    = 16'h0;
        result_nz   = 1'b0;
        mem_ack     = 1'b0;

        vecs[0]  = '{16'h5280, 16'h0000, 0, 0, 1'b1, 3, 1'b1, 2'b00, 4'h5, 1'b0}; // ADD R1,R2
        vecs[1]  = '{16'h4600, 16'hBEEF, 2, 0, 1'b0, 5, 1'b1, 2'b10, 4'h0, 1'b0}; // MVI late
        vecs[2]  = '{16'h1940, 16'h0000, 0, 3, 1'b0, 6, 1'b0, 2'b00, 4'h0, 1'b0}; // ST 3 waits
        vecs[3]  = '{16'h0940, 16'h0000, 0, 3, 1'b0, 6, 1'b1, 2'b11, 4'h0, 1'b0}; // LD 3 waits
        vecs[4]  = '{16'h6280, 16'h0000, 0, 0, 1'b0, 3, 1'b1, 2'b00, 4'h6, 1'b0}; // SUB NZ=0
        vecs[5]  = '{16'h2280, 16'h0000, 0, 0, 1'b0, 2, 1'b0, 2'b01, 4'h0, 1'b0}; // MVNZ off
        vecs[6]  = '{16'h7280, 16'h0000, 0, 0, 1'b1, 3, 1'b1, 2'b00, 4'h7, 1'b0}; // OR NZ=1
        vecs[7]  = '{16'h2280, 16'h0000, 0, 0, 1'b0, 2, 1'b1, 2'b01, 4'h0, 1'b0}; // MVNZ on
        vecs[8]  = '{16'hF000, 16'h0000, 0, 0, 1'b0, 1, 1'b0, 2'b00, 4'h0, 1'b1}; // illegal
        vecs[9]  = '{16'h3A40, 16'h0000, 0, 0, 1'b0, 2, 1'b1, 2'b01, 4'h0, 1'b0}; // MV R5,R1
        vecs[10] = '{16'h4E00, 16'h1234, 0, 0, 1'b0, 3, 1'b1, 2'b10, 4'h0, 1'b0}; // MVI b2b
        vecs[11] = '{16'h0BC0, 16'h0000, 0, 0, 1'b0, 3, 1'b1, 2'b11, 4'h0, 1'b0}; // LD no wait

        #1;
        chk("rst_ready", instr_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_immout", imm_out, 0);
        chk("rst_rdaddr_a", rd_addr_a, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", instr_ready, 1);
        chk("post_rst_done", done, 0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            do_instr(vecs[i].word, vecs[i].imm, vecs[i].d, vecs[i].w, vecs[i].nzin,
                     vecs[i].lat, vecs[i].rw, vecs[i].wbsel, vecs[i].ula, vecs[i].ill);
        end

        // Set NZ, then abort an LD in MEM with reset.
        do_instr(16'h7280, 16'h0, 0, 0, 1'b1, 3, 1'b1, 2'b00, 4'h7, 1'b0);
        instr_valid = 1'b1;
        instr_in    = 16'h0940;
        mem_ack     = 1'b0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_memreq_before", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_memreq", mem_req, 0);
        chk("abort_regwrite", reg_write, 0);
        chk("abort_ready", instr_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_rdaddr_b", rd_addr_b, 0);
        chk("abort_immout", imm_out, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold_done", done, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_release_ready", instr_ready, 1);
            chk("abort_release_done", done, 0);
        end
        @(posedge clk);
        #1;
        do_instr(16'h2280, 16'h0, 0, 0, 1'b0, 2, 1'b0, 2'b01, 4'h0, 1'b0);

        // Randomized stream against the instruction-level model.
        model_nz = 1'b0;
        for (int n = 0; n < 80; n++) begin
            r_word  = 16'($urandom);
            r_op    = r_word[15:12];
            r_imm   = 16'($urandom);
            r_d     = $urandom_range(0, 3);
            r_w     = $urandom_range(0, 3);
            r_nzin  = 1'($urandom);
            e_ill   = 1'b0;
            e_rw    = 1'b1;
            e_wbsel = 2'b00;
            e_ula   = 4'h0;
            if (r_op >= 4'd11) begin
                e_ill = 1'b1;
                e_lat = 1;
                e_rw  = 1'b0;
            end else if (r_op >= 4'd5) begin
                e_lat = 3;
                e_ula = r_op;
            end else if (r_op == 4'd4) begin
                e_lat   = 3 + r_d;
                e_wbsel = 2'b10;
            end else if (r_op == 4'd3) begin
                e_lat   = 2;
                e_wbsel = 2'b01;
            end else if (r_op == 4'd2) begin
                e_lat   = 2;
                e_wbsel = 2'b01;
                e_rw    = model_nz;
            end else if (r_op == 4'd1) begin
                e_lat = 3 + r_w;
                e_rw  = 1'b0;
            end else begin
                e_lat   = 3 + r_w;
                e_wbsel = 2'b11;
            end
            do_instr(r_word, r_imm, r_d, r_w, r_nzin, e_lat, e_rw, e_wbsel, e_ula, e_ill);
            if (r_op >= 4'd5 && r_op <= 4'd10) model_nz = r_nzin;
            if ($urandom_range(0, 3) == 0) begin
                instr_valid = 1'b0;
                @(negedge clk);
                chk("idle_ready", instr_ready, 1);
                chk("idle_done", done, 0);
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
